// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the byte-wide memory access controller:
//   FSM state encoding, word size in bytes and requester port ids.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 8;

    // Port ids double as the round-robin history value.
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_arb.sv
// mem_rr_arb2
//   Two-request round-robin picker. The grant is combinational from the
//   requests and the last_gnt history; history advances only on accept.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_f, req_d    fetch / data requests
//   accept          grant is being taken this cycle
//   gnt_valid       at least one request is high
//   gnt_port        port id of the winner (PORT_F / PORT_D)
module mem_rr_arb2
    import mem_access_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_d,
    input  logic accept,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_gnt;

    always_comb begin
        gnt_valid = req_f | req_d;
        gnt_port  = PORT_F;
        if (req_f && req_d) begin
            // Tie: the port that did not win last time goes now.
            gnt_port = ~last_gnt;
        end else if (req_d) begin
            gnt_port = PORT_D;
        end
    end

    // Reset to data so that fetch wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= PORT_D;
        end else if (accept && gnt_valid) begin
            last_gnt <= gnt_port;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Arbitrates 64-bit word requests from the fetch port (read-only) and the
//   data port (read/write) onto a byte-wide synchronous RAM. Each access is
//   eight byte cycles, big-endian (MSB at the lowest address). Addresses above
//   MEM_BYTES-8 are rejected with err and never reach the RAM.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   f_req/f_addr             fetch read request and byte address
//   f_done/f_rdata/f_err     fetch completion pulse, read word, range error
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, write word
//   d_done/d_rdata/d_err     data completion pulse, read word, range error
//   ram_addr/ram_we/ram_wdata/ram_rdata  byte RAM port (read data one cycle late)
//   busy                     high whenever the FSM is not IDLE
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic              f_done,
    output logic [63:0]       f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_done,
    output logic [63:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - WORD_BYTES);

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg;
    logic               port_reg;
    logic               we_reg;
    logic               err_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [63:0]        wdata_reg;
    logic [55:0]        shift_reg;

    logic               gnt_valid;
    logic               gnt_port;
    logic               accept;
    logic [63:0]        sel_addr;
    logic               sel_we;
    logic [63:0]        sel_wdata;
    logic               sel_illegal;
    logic [7:0]         wdata_bytes [WORD_BYTES];

    assign accept = (state_reg == IDLE);

    mem_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_f     (f_req),
        .req_d     (d_req),
        .accept    (accept),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Request fields of whichever port the arbiter picked this cycle.
    always_comb begin
        sel_addr  = f_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        if (gnt_port == PORT_D) begin
            sel_addr  = d_addr;
            sel_we    = d_we;
            sel_wdata = d_wdata;
        end
    end

    // Full-width compare so huge addresses cannot alias into the RAM.
    assign sel_illegal = (sel_addr > LAST_LEGAL);

    // Byte k of the word is bits 63-8k down; lane 0 is the MSB.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign wdata_bytes[gi] = wdata_reg[63-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    if (sel_illegal)  state_next = DONE;
                    else if (sel_we)  state_next = WRITE;
                    else              state_next = READ;
                end
            end
            READ:    if (cnt_reg == 4'd8) state_next = DONE;
            WRITE:   if (cnt_reg == 4'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM port and completion outputs decode from the registered state.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_reg == WRITE) begin
            ram_we    = 1'b1;
            ram_addr  = addr_reg + ADDR_W'(cnt_reg);
            ram_wdata = wdata_bytes[cnt_reg[2:0]];
        end else if (state_reg == READ && cnt_reg != 4'd8) begin
            // cnt 8 only collects the last byte; no new address needed.
            ram_addr = addr_reg + ADDR_W'(cnt_reg);
        end
    end

    assign busy   = (state_reg != IDLE);
    assign f_done = (state_reg == DONE) && (port_reg == PORT_F);
    assign d_done = (state_reg == DONE) && (port_reg == PORT_D);
    assign f_err  = f_done && err_reg;
    assign d_err  = d_done && err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            port_reg  <= PORT_F;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            shift_reg <= '0;
            f_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (gnt_valid) begin
                        port_reg  <= gnt_port;
                        we_reg    <= sel_we;
                        err_reg   <= sel_illegal;
                        addr_reg  <= sel_addr[ADDR_W-1:0];
                        wdata_reg <= sel_wdata;
                    end
                end
                READ: begin
                    // Read data lags the address by one cycle, so bytes
                    // arrive on cnt 1..8 and are shifted in MSB first.
                    if (cnt_reg != 4'd0) begin
                        shift_reg <= {shift_reg[47:0], ram_rdata};
                    end
                    if (cnt_reg == 4'd8) begin
                        cnt_reg <= '0;
                        if (port_reg == PORT_F) f_rdata <= {shift_reg, ram_rdata};
                        else                    d_rdata <= {shift_reg, ram_rdata};
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                WRITE: begin
                    cnt_reg <= (cnt_reg == 4'd7) ? 4'd0 : cnt_reg + 4'd1;
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    // we_reg is informational: the FSM already chose READ/WRITE at grant.
    logic unused_we;
    assign unused_we = we_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl with a 4096-byte synchronous-read RAM
//   model. Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [63:0] f_addr;
    logic        f_done;
    logic [63:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_err;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int dd_cnt = 0;

    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(4096), .ADDR_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // Synchronous-read byte RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (d_done) dd_cnt <= dd_cnt + 1;
    end

    function automatic logic [63:0] mem_word(input logic [11:0] a);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[55:0], mem[a + 12'(i)]};
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one request on a port (1 = data), wait for its done pulse and
    // return the cycle index (request sampled in cycle 0) and err flag.
    // Returns with the controller back in IDLE.
    task automatic do_req(input logic port, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, output int cyc, output logic err);
        cyc = -1;
        err = 1'bx;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (port ? d_done : f_done) begin
                cyc = n;
                err = port ? d_err : f_err;
                break;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        $display("[TB] %s %s addr=0x%h cycles=%0d err=%b",
                 port ? "D" : "F", we ? "write" : "read ", addr, cyc, err);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        logic        err;
        int          w0;
        int          d0;
        int          k;
        logic [3:0]  seq;
        int          at [4];

        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_ctrl_outputs",
              64'({busy, f_done, f_err, d_done, d_err, ram_we, ram_wdata, ram_addr}), 64'd0);
        check("reset_f_rdata", f_rdata, 64'd0);
        check("reset_d_rdata", d_rdata, 64'd0);

        // Write then read back
        do_req(1'b1, 1'b1, 64'h100, 64'h0123456789ABCDEF, cyc, err);
        check("wr100_cycles", 64'(cyc), 64'd9);
        check("wr100_err", 64'(err), 64'd0);
        check("wr100_ram", mem_word(12'h100), 64'h0123456789ABCDEF);

        do_req(1'b0, 1'b0, 64'h100, 64'd0, cyc, err);
        check("frd100_cycles", 64'(cyc), 64'd10);
        check("frd100_err", 64'(err), 64'd0);
        check("frd100_data", f_rdata, 64'h0123456789ABCDEF);

        // Range boundary
        do_req(1'b1, 1'b1, 64'hFF8, 64'hA5A55A5A0F0FF0F0, cyc, err);
        check("wrFF8_cycles", 64'(cyc), 64'd9);
        check("wrFF8_err", 64'(err), 64'd0);
        check("wrFF8_ram", mem_word(12'hFF8), 64'hA5A55A5A0F0FF0F0);

        do_req(1'b1, 1'b0, 64'hFF8, 64'd0, cyc, err);
        check("drdFF8_cycles", 64'(cyc), 64'd10);
        check("drdFF8_err", 64'(err), 64'd0);
        check("drdFF8_data", d_rdata, 64'hA5A55A5A0F0FF0F0);

        w0 = we_cnt;
        do_req(1'b1, 1'b0, 64'hFF9, 64'd0, cyc, err);
        check("rdFF9_cycles", 64'(cyc), 64'd1);
        check("rdFF9_err", 64'(err), 64'd1);
        check("rdFF9_rdata_held", d_rdata, 64'hA5A55A5A0F0FF0F0);

        do_req(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h1111111111111111, cyc, err);
        check("wrHuge_cycles", 64'(cyc), 64'd1);
        check("wrHuge_err", 64'(err), 64'd1);
        check("illegal_no_ram_we", 64'(we_cnt - w0), 64'd0);
        check("illegal_ram_intact", mem_word(12'hFF8), 64'hA5A55A5A0F0FF0F0);
        check("illegal_rdata_held", d_rdata, 64'hA5A55A5A0F0FF0F0);

        // Contention out of reset: both held for four transactions
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'hFF8;
        seq = '0;
        k = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (f_done || d_done) begin
                seq = {seq[2:0], d_done};
                at[k] = n;
                $display("[TB] contention grant %0d to %s done at cycle %0d", k, d_done ? "D" : "F", n);
                k++;
            end
            if (k == 4) break;
        end
        f_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("cont_count", 64'(k), 64'd4);
        check("cont_order_FDFD", 64'(seq), 64'b0101);
        check("cont_first_done", 64'(at[0]), 64'd10);
        check("cont_second_done", 64'(at[1]), 64'd21);
        check("cont_fourth_done", 64'(at[3]), 64'd43);
        check("cont_f_rdata", f_rdata, 64'h0123456789ABCDEF);
        check("cont_d_rdata", d_rdata, 64'hA5A55A5A0F0FF0F0);

        // Request hold and mid-READ address change
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) d_addr = 64'hFF8;
            if (d_done) begin
                cyc = n;
                break;
            end
        end
        $display("[TB] D read  addr=0x100 (held) cycles=%0d", cyc);
        check("hold1_cycles", 64'(cyc), 64'd10);
        check("hold1_data", d_rdata, 64'h0123456789ABCDEF);
        @(posedge clk);
        @(negedge clk);
        check("hold_gap_idle", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_restart_busy", 64'(busy), 64'd1);
        cyc = -1;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_done) begin
                cyc = n;
                break;
            end
        end
        d_req = 1'b0;
        $display("[TB] D read  addr=0xff8 (held) cycles=%0d", cyc);
        @(negedge clk);
        check("hold2_cycles", 64'(cyc), 64'd10);
        check("hold2_data", d_rdata, 64'hA5A55A5A0F0FF0F0);

        // Reset in the middle of a write
        do_req(1'b1, 1'b1, 64'h200, 64'hDEADBEEFCAFEF00D, cyc, err);
        check("pre_wr200_ram", mem_word(12'h200), 64'hDEADBEEFCAFEF00D);
        d0 = dd_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'h1122334455667788;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midwr_ram_addr", 64'(ram_addr), 64'h203);
        check("midwr_ram_we", 64'(ram_we), 64'd1);
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        check("rst_ctrl_outputs",
              64'({busy, f_done, f_err, d_done, d_err, ram_we, ram_wdata, ram_addr}), 64'd0);
        check("rst_rdata", f_rdata | d_rdata, 64'd0);
        @(negedge clk);
        check("rst_held_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] D write addr=0x200 aborted by reset at cnt=3");
        check("partial_write_ram", mem_word(12'h200), 64'h112233EFCAFEF00D);
        check("partial_no_done", 64'(dd_cnt - d0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing and arbitration controller for the processor's shared byte-wide memory. Accepts 64-bit word requests from two requesters, the fetch stage (read-only) and the memory stage (read/write). Grants one requester at a time by round-robin and performs each access as eight single-byte RAM cycles in big-endian order, with the most significant byte at the lowest address. Out-of-range addresses are rejected with an error response and never touch the RAM; this response is the source of the processor's dmem_error status.

## Interface
- MEM_BYTES, 4096: RAM size in bytes
- ADDR_W, 12: RAM address width, log2(MEM_BYTES)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request, held until f_done
- f_addr  in  64  fetch byte address
- f_done  out  1  one-cycle completion pulse
- f_rdata  out  64  fetch read word
- f_err  out  1  valid with f_done; address out of range
- d_req  in  1  memory-stage request, held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  64  data byte address
- d_wdata  in  64  write word
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  64  data read word
- d_err  out  1  valid with d_done; address out of range
- ram_addr  out  ADDR_W  RAM byte address
- ram_we  out  1  RAM byte write enable
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte, synchronous, valid the cycle after ram_addr
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: no access in progress; arbitration happens here.
  - READ: ram_we=0.
    - cnt 0..8.
    - For cnt 0..7, ram_addr = base+cnt.
    - For cnt 1..8, ram_rdata goes into byte lane cnt-1, where lane 0 is bits 63:56.
  - WRITE: ram_we=1.
    - cnt 0..7.
    - ram_addr = base+cnt, ram_wdata = wdata[63-8*cnt -: 8].
  - DONE: one cycle.
    - Pulses the granted port's done; err is set if the access was rejected.
    - Returns to IDLE.
- Arbitration in IDLE:
  - If only one request is high, that requester is granted.
  - If both are high, the requester not granted last time wins.
  - last_gnt is updated on every grant.
- Grant latches the port id, addr, we and wdata into internal registers; later changes on the request inputs are ignored.
- Range check: an address is illegal if addr > MEM_BYTES-8, using a full 64-bit unsigned compare.
  - An illegal address goes IDLE to DONE with err=1 and no RAM cycles.
  - The rdata registers are unchanged on an error.
- On a legal read, the granted port's rdata register is updated at the end of READ and then held until that port's next successful read.
- The fetch port never writes.
- A requester dropping req mid-transaction does not abort it; done still pulses.
- A requester holding req through done is treated as a new request in the following IDLE cycle.
- Idle outputs: ram_we=0, ram_addr=0, ram_wdata=0.

## Timing
- Cycle 0: IDLE samples the requests; state is registered at the end of the cycle.
- Legal read: cycles 1–9 READ, cycle 10 DONE. Done pulses 10 cycles after the request is sampled.
- Legal write: cycles 1–8 WRITE, cycle 9 DONE. RAM byte k is written at the end of cycle k+1.
- Error: cycle 1 DONE with err=1.
- Minimum gap is one IDLE cycle between transactions.
- Throughput:
  - 11 cycles per back-to-back read.
  - 10 cycles per back-to-back write.
- Reset values: state=IDLE, cnt=0, last_gnt=data (fetch wins the first tie), all outputs 0 including f_rdata and d_rdata.
- Reset mid-transaction: immediate return to IDLE with no done pulse.
  - A partial write (bytes 0..k) stays in the RAM.
  - A partial read leaves rdata unchanged.
- Simultaneous requests in IDLE are resolved as described under Arbitration; the loser waits at least one full transaction.

## Structure
- Package mem_access_pkg holds:
  - state enum (IDLE, READ, WRITE, DONE);
  - WORD_BYTES=8;
  - port id constants PORT_F=0, PORT_D=1.
- Sub-module mem_rr_arb2: two-request round-robin picker.
  - Combinational grant output plus a last_gnt register that updates on an accept strobe.
- The byte-lane shift and capture, the range check and the counter stay in the top module.
- The bench provides a 4096-byte synchronous-read RAM model.

## Test plan
- Write then read back:
  - d_we=1, d_addr=0x100, d_wdata=0x0123456789ABCDEF; the RAM must hold bytes 0x01..0xEF at 0x100..0x107 and d_done must pulse at cycle 9.
  - A following f_req at 0x100 must return f_rdata=0x0123456789ABCDEF with f_done at cycle 10.
- Range boundary:
  - d_addr=0xFF8 must succeed with d_err=0.
  - d_addr=0xFF9 and d_addr=0xFFFFFFFFFFFFFFF8 must each pulse d_err=1 at cycle 1, with ram_we never asserted and d_rdata unchanged.
- Contention:
  - f_req and d_req high together out of reset: fetch is granted first, then data.
  - With both held, grants must alternate F, D, F, D over 4 transactions.
- Request hold:
  - d_req held through d_done must start a second access after exactly one IDLE cycle.
  - Changing d_addr mid-READ must not affect the returned word.
- Reset mid-write:
  - Assert rst during WRITE cnt=3.
  - Bytes 0..2 must be written and bytes 3..7 must be untouched; no d_done; all outputs 0; busy=0 while rst is held.
